// File: rtl/proc_decode_pkg.sv
// Shared definitions for the decode skid stage: instruction field layout,
// stage state encoding and the flush drop counter width.
package proc_decode_pkg;

    localparam int INSN_W        = 32;
    localparam int FIELD_W       = 5;
    localparam int FLUSH_DROPS_W = 8;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int RD_MSB     = 26;
    localparam int RD_LSB     = 22;
    localparam int RS_MSB     = 21;
    localparam int RS_LSB     = 17;
    localparam int RT_MSB     = 16;
    localparam int RT_LSB     = 12;
    localparam int IMM_MSB    = 16;
    localparam int TARGET_MSB = 26;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_t;

    typedef struct packed {
        logic [FIELD_W-1:0] opcode;
        logic [FIELD_W-1:0] rd;
        logic [FIELD_W-1:0] rs;
        logic [FIELD_W-1:0] rt;
        logic [INSN_W-1:0]  imm32;
        logic [INSN_W-1:0]  target32;
    } decoded_t;

endpackage

// File: rtl/insn_field_decode.sv
// Pure combinational split of an instruction word into register fields and
// sign-extended immediate / jump target.
module insn_field_decode
    import proc_decode_pkg::*;
(
    input  logic [INSN_W-1:0] insn,
    output decoded_t          fields
);

    always_comb begin
        fields.opcode   = insn[OPCODE_MSB:OPCODE_LSB];
        fields.rd       = insn[RD_MSB:RD_LSB];
        fields.rs       = insn[RS_MSB:RS_LSB];
        fields.rt       = insn[RT_MSB:RT_LSB];
        fields.imm32    = {{(INSN_W-1-IMM_MSB){insn[IMM_MSB]}}, insn[IMM_MSB:0]};
        fields.target32 = {{(INSN_W-1-TARGET_MSB){insn[TARGET_MSB]}}, insn[TARGET_MSB:0]};
    end

endmodule

// File: rtl/decode_skid_stage.sv
// Two-entry decode stage: a registered output slot plus a skid slot so that
// in_ready depends only on registered state.
module decode_skid_stage
    import proc_decode_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSN_W-1:0]        in_insn,
    input  logic [INSN_W-1:0]        in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSN_W-1:0]        out_insn,
    output logic [INSN_W-1:0]        out_pc,
    output logic [FIELD_W-1:0]       out_opcode,
    output logic [FIELD_W-1:0]       out_rd,
    output logic [FIELD_W-1:0]       out_rs,
    output logic [FIELD_W-1:0]       out_rt,
    output logic [INSN_W-1:0]        out_imm32,
    output logic [INSN_W-1:0]        out_target32,
    output logic [FLUSH_DROPS_W-1:0] flush_drops,
    output stage_state_t             dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; a producer holding valid keeps its payload stable until then.
    stage_state_t            state_q, state_d;
    logic [INSN_W-1:0]       skid_insn_q, skid_pc_q;
    decoded_t                in_dec, skid_dec;
    logic                    accept, emit;
    logic                    load_out_in, load_out_skid, load_skid;
    logic [1:0]              kill_cnt;
    logic [FLUSH_DROPS_W:0]  drops_sum;
    logic [FLUSH_DROPS_W-1:0] drops_d;

    insn_field_decode u_dec_in   (.insn(in_insn),     .fields(in_dec));
    insn_field_decode u_dec_skid (.insn(skid_insn_q), .fields(skid_dec));

    assign in_ready  = (state_q != ST_SKID);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;
    assign dbg_state = state_q;

    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        kill_cnt      = 2'd0;
        if (flush) begin
            // An entry leaving on this edge counts as delivered, not killed.
            state_d = ST_EMPTY;
            case (state_q)
                ST_FULL: kill_cnt = emit ? 2'd0 : 2'd1;
                ST_SKID: kill_cnt = emit ? 2'd1 : 2'd2;
                default: kill_cnt = 2'd0;
            endcase
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        load_out_in = 1'b1;
                        state_d     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && emit) begin
                        load_out_in = 1'b1;
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (emit) begin
                        load_out_skid = 1'b1;
                        state_d       = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign drops_sum = {1'b0, flush_drops} + {{(FLUSH_DROPS_W-1){1'b0}}, kill_cnt};
    assign drops_d   = drops_sum[FLUSH_DROPS_W] ? '1 : drops_sum[FLUSH_DROPS_W-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            flush_drops  <= '0;
            skid_insn_q  <= '0;
            skid_pc_q    <= '0;
            out_insn     <= '0;
            out_pc       <= '0;
            out_opcode   <= '0;
            out_rd       <= '0;
            out_rs       <= '0;
            out_rt       <= '0;
            out_imm32    <= '0;
            out_target32 <= '0;
        end else begin
            state_q     <= state_d;
            flush_drops <= drops_d;
            if (load_skid) begin
                skid_insn_q <= in_insn;
                skid_pc_q   <= in_pc;
            end
            if (load_out_in) begin
                out_insn     <= in_insn;
                out_pc       <= in_pc;
                out_opcode   <= in_dec.opcode;
                out_rd       <= in_dec.rd;
                out_rs       <= in_dec.rs;
                out_rt       <= in_dec.rt;
                out_imm32    <= in_dec.imm32;
                out_target32 <= in_dec.target32;
            end else if (load_out_skid) begin
                out_insn     <= skid_insn_q;
                out_pc       <= skid_pc_q;
                out_opcode   <= skid_dec.opcode;
                out_rd       <= skid_dec.rd;
                out_rs       <= skid_dec.rs;
                out_rt       <= skid_dec.rt;
                out_imm32    <= skid_dec.imm32;
                out_target32 <= skid_dec.target32;
            end
        end
    end

endmodule

// File: tb/tb_decode_skid_stage.sv
// Directed bench for decode_skid_stage: decode vector table, skid backpressure,
// flush accounting/saturation and asynchronous reset.
module tb_decode_skid_stage;
    import proc_decode_pkg::*;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_insn = '0;
    logic [31:0]  in_pc = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_insn, out_pc, out_imm32, out_target32;
    logic [4:0]   out_opcode, out_rd, out_rs, out_rt;
    logic [7:0]   flush_drops;
    stage_state_t dbg_state;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [4:0]  op, rd, rs, rt;
        logic [31:0] imm, tgt;
    } vec_t;
    vec_t vecs[6];

    decode_skid_stage dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_insn(out_insn), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
        .out_imm32(out_imm32), .out_target32(out_target32),
        .flush_drops(flush_drops), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard check of the transfer about to happen, then advance one cycle.
    task automatic step();
        @(negedge clock);
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got 0x%08h want nothing", out_insn);
            end else begin
                chk("sb_order", out_insn, exp_q.pop_front());
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h2841FFFF, 32'h10, 5'd5,  5'd1,  5'd0,  5'd31, 32'hFFFFFFFF, 32'h0041FFFF};
        vecs[1] = '{32'h0C000010, 32'h14, 5'd1,  5'd16, 5'd0,  5'd0,  32'h00000010, 32'hFC000010};
        vecs[2] = '{32'h08000010, 32'h18, 5'd1,  5'd0,  5'd0,  5'd0,  32'h00000010, 32'h00000010};
        vecs[3] = '{32'h87654321, 32'h1C, 5'd16, 5'd29, 5'd18, 5'd20, 32'hFFFF4321, 32'hFF654321};
        vecs[4] = '{32'h7FFE0000, 32'h20, 5'd15, 5'd31, 5'd31, 5'd0,  32'h00000000, 32'hFFFE0000};
        vecs[5] = '{32'hFFFFFFFF, 32'h24, 5'd31, 5'd31, 5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF};

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_insn", out_insn, 32'd0);
        chk("rst_out_imm32", out_imm32, 32'd0);
        chk("rst_drops", 32'(flush_drops), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_EMPTY));

        // Decode table, streamed back to back; first accept on first edge after reset.
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_insn  = vecs[i].insn;
            in_pc    = vecs[i].pc;
            exp_q.push_back(vecs[i].insn);
            step();
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_insn", out_insn, vecs[i].insn);
            chk("tbl_pc", out_pc, vecs[i].pc);
            chk("tbl_opcode", 32'(out_opcode), 32'(vecs[i].op));
            chk("tbl_rd", 32'(out_rd), 32'(vecs[i].rd));
            chk("tbl_rs", 32'(out_rs), 32'(vecs[i].rs));
            chk("tbl_rt", 32'(out_rt), 32'(vecs[i].rt));
            chk("tbl_imm32", out_imm32, vecs[i].imm);
            chk("tbl_target32", out_target32, vecs[i].tgt);
        end
        in_valid = 1'b0;
        step();
        chk("tbl_drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: A, B, C offered while out_ready=0.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_insn   = 32'hA0000001; in_pc = 32'h100;
        exp_q.push_back(in_insn);
        step();
        chk("bp_a_valid", 32'(out_valid), 32'd1);
        chk("bp_a_ready", 32'(in_ready), 32'd1);
        in_insn = 32'hB0000002; in_pc = 32'h104;
        exp_q.push_back(in_insn);
        step();
        chk("bp_b_ready", 32'(in_ready), 32'd0);
        chk("bp_b_state", 32'(dbg_state), 32'(ST_SKID));
        chk("bp_b_hold", out_insn, 32'hA0000001);
        in_insn = 32'hC0000003; in_pc = 32'h108;
        step();
        chk("bp_c_ready", 32'(in_ready), 32'd0);
        chk("bp_c_hold", out_insn, 32'hA0000001);
        chk("bp_c_hold_pc", out_pc, 32'h100);
        out_ready = 1'b1;
        exp_q.push_back(in_insn);
        step();
        chk("bp_out_b", out_insn, 32'hB0000002);
        chk("bp_out_b_pc", out_pc, 32'h104);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_out_c", out_insn, 32'hC0000003);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Flush in SKID without emit: two entries killed, same-cycle input discarded.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_insn   = 32'h11111111;
        step();
        in_insn = 32'h22222222;
        step();
        flush   = 1'b1;
        in_insn = 32'h33333333;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        chk("fl_drops", 32'(flush_drops), 32'd2);
        chk("fl_state", 32'(dbg_state), 32'(ST_EMPTY));
        out_ready = 1'b1;
        step();
        step();
        chk("fl_no_z", 32'(out_valid), 32'd0);

        // Flush in FULL while emitting: delivered entry is not counted.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_insn   = 32'h44444444;
        exp_q.push_back(in_insn);
        step();
        in_valid  = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("fl_full_emit_drops", 32'(flush_drops), 32'd2);
        chk("fl_full_emit_valid", 32'(out_valid), 32'd0);

        // Flush in SKID while emitting: only the skid entry is killed.
        in_valid = 1'b1;
        in_insn  = 32'h55555555;
        exp_q.push_back(in_insn);
        step();
        in_insn = 32'h66666666;
        step();
        in_valid  = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("fl_skid_emit_drops", 32'(flush_drops), 32'd3);

        // Repeated SKID flushes must saturate at 255.
        for (int k = 0; k < 130; k++) begin
            in_valid = 1'b1;
            in_insn  = 32'h70000000 + 32'(k);
            step();
            step();
            in_valid = 1'b0;
            flush    = 1'b1;
            step();
            flush = 1'b0;
            if (k == 0) chk("sat_first", 32'(flush_drops), 32'd5);
        end
        chk("sat_drops", 32'(flush_drops), 32'd255);
        chk("sat_state", 32'(dbg_state), 32'(ST_EMPTY));

        // Asynchronous reset pulse while FULL: entry is never emitted.
        in_valid = 1'b1;
        in_insn  = 32'h99999999;
        step();
        in_valid = 1'b0;
        chk("ar_full", 32'(out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd1);
        chk("ar_drops", 32'(flush_drops), 32'd0);
        chk("ar_insn", out_insn, 32'd0);
        #2;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("ar_no_emit", 32'(out_valid), 32'd0);
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_skid_stage.md
DECODE_SKID_STAGE -- requirements
Module: decode_skid_stage

Interface
REQ-001 SHALL have port clock, input, 1, sole clock, rising-edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_insn (input, 32): upstream fetch handshake and instruction word.
REQ-004 SHALL have port in_pc, input, 32, PC of in_insn.
REQ-005 SHALL have port flush, input, 1, synchronous kill of all held entries.
REQ-006 SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream execute handshake.
REQ-007 SHALL have ports out_insn and out_pc, output, 32 each, registered copies of the accepted instruction and PC.
REQ-008 SHALL have ports out_opcode, out_rd, out_rs and out_rt, output, 5 each, from insn[31:27], [26:22], [21:17] and [16:12].
REQ-009 SHALL have port out_imm32, output, 32, insn[16:0] sign-extended from bit 16.
REQ-010 SHALL have port out_target32, output, 32, insn[26:0] sign-extended from bit 26.
REQ-011 SHALL have port flush_drops, output, 8, saturating count of valid entries killed by flush.

Function
REQ-012 SHALL accept input on in_valid&in_ready and emit output on out_valid&out_ready, both sampled at the rising edge.
REQ-013 SHALL hold state EMPTY (nothing held), FULL (output register valid) or SKID (output and skid registers valid).
REQ-014 SHALL drive in_ready=1 in EMPTY and FULL and in_ready=0 in SKID, from registered state only, with no combinational in->out path.
REQ-015 SHALL compute all decoded fields and extensions when an entry is captured; outputs SHALL be registers.
REQ-016 SHALL give 1-cycle latency: an input accepted at edge N appears on out_* with out_valid=1 after edge N when the stage was EMPTY.
REQ-017 EMPTY SHALL go to FULL on accept, else stay EMPTY.
REQ-018 FULL SHALL: on accept and emit, load the output register with the new entry and stay FULL; on emit only, go to EMPTY; on accept only, write the entry into skid and go to SKID.
REQ-019 SKID SHALL, on emit, move the skid entry to the output register and go to FULL; otherwise it SHALL hold.
REQ-020 SHALL keep all out_* stable while out_valid=1 and out_ready=0.
REQ-021 SHALL preserve program order and never duplicate or drop an entry except on flush.
REQ-022 SHALL give flush priority over all events: the next state is EMPTY, the same-cycle input is discarded and any same-cycle emit still counts as delivered.
REQ-023 On flush, SHALL add to flush_drops the number of killed held entries (0-2, excluding an entry emitted that cycle), saturating at 255.
REQ-024 SHALL leave data registers unchanged when their valid bit is 0; the bench SHALL NOT check them then.

Reset
REQ-025 On reset_n=0, SHALL immediately go to state EMPTY with out_valid=0, in_ready=1, all data outputs 0 and flush_drops=0.
REQ-026 Assertion mid-handshake SHALL discard both held entries without completing any transfer.
REQ-027 The first accept after reset_n rises SHALL be possible at the first rising edge.

Structure
REQ-028 Shared package proc_decode_pkg SHALL hold the instruction field bit positions, the state encoding constants (EMPTY/FULL/SKID) and the flush_drops width.
REQ-029 One combinational sub-module, insn_field_decode, SHALL split a 32-bit word into opcode/rd/rs/rt/imm32/target32 and SHALL be instantiated once per capture path.

Verification
REQ-030 Reset, then in_insn=0x2841FFFF with in_pc=0x10 and out_ready=1 -> next cycle out_valid=1, out_opcode=5, out_rd=1, out_rs=0, out_imm32=0xFFFFFFFF.
REQ-031 in_insn=0x0C000010 -> out_opcode=1, out_target32=0xFC000010; in_insn=0x08000010 -> out_target32=0x00000010.
REQ-032 out_ready=0 for 3 cycles while A, B, C are offered -> A and B accepted, in_ready=0 from the cycle after B, outputs hold A; out_ready=1 -> A, B, C emitted in order.
REQ-033 Flush in SKID with out_ready=0 -> next cycle out_valid=0, in_ready=1, flush_drops=2, same-cycle input absent from output.
REQ-034 Flush repeated 130 times in SKID -> flush_drops=255, not wrapping.
REQ-035 reset_n pulse low, asynchronous to the clock, while in FULL -> out_valid=0 at once; entry never emitted; flush_drops=0.
